ff_array_access_ctrl: RTL and testbench

//   Initiator side of the flip-flop array port: accepts read/write requests over a

---
 rtl/ff_array_access_ctrl_if.sv | 29 ++
 rtl/ff_array_access_ctrl.sv | 108 ++++++++++
 tb/tb_ff_array_access_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ff_array_access_ctrl_if.sv
// ff_array_access_ctrl_if: request/response channels and array port of the flip-flop array initiator
interface ff_array_access_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [DATA_W-1:0] arr_din;
  logic [ADDR_W-1:0] arr_addr;
  logic              arr_wr;
  logic              arr_rd;
  logic [DATA_W-1:0] arr_dout;
  logic              arr_error;
  modport master (
    output req_valid, req_wr, req_addr, req_data, rsp_ready, arr_dout, arr_error,
    input  req_ready, rsp_valid, rsp_data, rsp_err, arr_din, arr_addr, arr_wr, arr_rd
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_data, rsp_ready, arr_dout, arr_error,
    output req_ready, rsp_valid, rsp_data, rsp_err, arr_din, arr_addr, arr_wr, arr_rd
  );
endinterface

// File: rtl/ff_array_access_ctrl.sv
// ff_array_access_ctrl: single-outstanding initiator for the flip-flop array with post-reset clear sweep
module ff_array_access_ctrl #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 3,
  parameter int              DATA_N   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  ff_array_access_ctrl_if.slave bus,
  output logic                 init_done,
  output logic [7:0]           err_cnt
);
  typedef enum logic [1:0] {INIT, IDLE, ISSUE, RESP} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, arr_addr_q, arr_addr_d;
  logic [DATA_W-1:0] arr_din_q, arr_din_d, rsp_data_q, rsp_data_d;
  logic              arr_wr_q, arr_wr_d, arr_rd_q, arr_rd_d;
  logic              wr_q, wr_d, oor_q, oor_d, rsp_err_q, rsp_err_d, init_done_q, init_done_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              req_oor;
  assign req_oor = {1'b0, bus.req_addr} >= (ADDR_W+1)'(DATA_N);
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    arr_addr_d  = arr_addr_q;
    arr_din_d   = arr_din_q;
    arr_wr_d    = 1'b0;
    arr_rd_d    = 1'b0;
    wr_d        = wr_q;
    oor_d       = oor_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    init_done_d = init_done_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      INIT: begin
        if (arr_wr_q && arr_addr_q == ADDR_W'(DATA_N-1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          arr_wr_d   = 1'b1;
          arr_addr_d = idx_q;
          arr_din_d  = INIT_VAL;
          idx_d      = idx_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (bus.req_valid) begin
          state_d    = ISSUE;
          wr_d       = bus.req_wr;
          oor_d      = req_oor;
          arr_wr_d   = bus.req_wr & ~req_oor;
          arr_rd_d   = ~bus.req_wr & ~req_oor;
          arr_addr_d = req_oor ? arr_addr_q : bus.req_addr;
          arr_din_d  = bus.req_data;
        end
      end
      ISSUE: begin
        state_d    = RESP;
        rsp_err_d  = oor_q | bus.arr_error;
        rsp_data_d = (wr_q || rsp_err_d) ? '0 : bus.arr_dout;
        err_cnt_d  = (rsp_err_d && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
      end
      RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= INIT;
      idx_q       <= '0;
      arr_addr_q  <= '0;
      arr_din_q   <= '0;
      arr_wr_q    <= 1'b0;
      arr_rd_q    <= 1'b0;
      wr_q        <= 1'b0;
      oor_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      init_done_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      arr_addr_q  <= arr_addr_d;
      arr_din_q   <= arr_din_d;
      arr_wr_q    <= arr_wr_d;
      arr_rd_q    <= arr_rd_d;
      wr_q        <= wr_d;
      oor_q       <= oor_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      init_done_q <= init_done_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.arr_din   = arr_din_q;
  assign bus.arr_addr  = arr_addr_q;
  assign bus.arr_wr    = arr_wr_q;
  assign bus.arr_rd    = arr_rd_q;
  assign init_done     = init_done_q;
  assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_ff_array_access_ctrl.sv
// tb_ff_array_access_ctrl: two controllers (DATA_N=8 and DATA_N=6) driven in lockstep against array models and a transaction-level reference
module tb_ff_array_access_ctrl;
  logic       clk = 1'b0, resetn = 1'b0;
  logic       req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0, err_inj = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       done0, done1;
  logic [7:0] cnt0, cnt1;
  logic [7:0] mem0 [8] = '{default: 8'h5a};
  logic [7:0] mem1 [8] = '{default: 8'h5a};
  logic [7:0] ref0 [8];
  logic [7:0] ref1 [8];
  int rc0 = 0, rc1 = 0;
  int nwr0 = 0, nrd0 = 0, nwr1 = 0, nrd1 = 0, nboth = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ff_array_access_ctrl_if #(.DATA_W(8), .ADDR_W(3)) b0 ();
  ff_array_access_ctrl_if #(.DATA_W(8), .ADDR_W(3)) b1 ();
  assign b0.req_valid = req_valid;
  assign b0.req_wr    = req_wr;
  assign b0.req_addr  = req_addr;
  assign b0.req_data  = req_data;
  assign b0.rsp_ready = rsp_ready;
  assign b0.arr_dout  = mem0[b0.arr_addr];
  assign b0.arr_error = err_inj;
  assign b1.req_valid = req_valid;
  assign b1.req_wr    = req_wr;
  assign b1.req_addr  = req_addr;
  assign b1.req_data  = req_data;
  assign b1.rsp_ready = rsp_ready;
  assign b1.arr_dout  = mem1[b1.arr_addr];
  assign b1.arr_error = err_inj;
  ff_array_access_ctrl #(.DATA_W(8), .ADDR_W(3), .DATA_N(8), .INIT_VAL(8'h00)) u0 (
    .clk(clk), .resetn(resetn), .bus(b0), .init_done(done0), .err_cnt(cnt0));
  ff_array_access_ctrl #(.DATA_W(8), .ADDR_W(3), .DATA_N(6), .INIT_VAL(8'h00)) u1 (
    .clk(clk), .resetn(resetn), .bus(b1), .init_done(done1), .err_cnt(cnt1));
  always @(posedge clk) begin
    nwr0  <= nwr0 + int'(b0.arr_wr);
    nrd0  <= nrd0 + int'(b0.arr_rd);
    nwr1  <= nwr1 + int'(b1.arr_wr);
    nrd1  <= nrd1 + int'(b1.arr_rd);
    nboth <= nboth + int'(b0.arr_wr & b0.arr_rd) + int'(b1.arr_wr & b1.arr_rd);
    if (b0.arr_wr) mem0[b0.arr_addr] <= b0.arr_din;
    if (b1.arr_wr) mem1[b1.arr_addr] <= b1.arr_din;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset(input int n);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    err_inj   = 1'b0;
    resetn    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_valid_ready", 32'({b1.rsp_valid, b1.req_ready, b0.rsp_valid, b0.req_ready}), 32'(0));
    chk("rst_init_done", 32'({done1, done0}), 32'(0));
    chk("rst_err_cnt", 32'({cnt1, cnt0}), 32'(0));
    chk("rst_strobes", 32'({b1.arr_wr, b1.arr_rd, b0.arr_wr, b0.arr_rd}), 32'(0));
    chk("rst_addr_din", 32'({b1.arr_addr, b1.arr_din, b0.arr_addr, b0.arr_din}), 32'(0));
    chk("rst_rsp", 32'({b1.rsp_data, b1.rsp_err, b0.rsp_data, b0.rsp_err}), 32'(0));
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("sweep0", 32'({b0.arr_wr, b0.arr_rd, b0.req_ready, done0, b0.arr_addr, b0.arr_din}),
          32'({4'b1000, 3'(i), 8'h00}));
      chk("sweep1", 32'({b1.arr_wr, b1.arr_rd, b1.req_ready, done1, b1.arr_addr, b1.arr_din}),
          32'({(i < 6) ? 4'b1000 : 4'b0011, (i < 6) ? 3'(i) : 3'd5, 8'h00}));
    end
    @(posedge clk); #1;
    chk("sweep_done0", 32'({b0.arr_wr, b0.arr_rd, b0.req_ready, done0}), 32'(4'b0011));
    for (int k = 0; k < 8; k++) begin
      ref0[k] = 8'h00;
      ref1[k] = 8'h00;
    end
    rc0 = 0;
    rc1 = 0;
  endtask
  task automatic txn(input bit wr, input logic [2:0] a, input logic [7:0] d, input bit inj,
                     input int hold, input bit rst_mid);
    logic [7:0] e0d, e1d;
    bit e0e, e1e, in1;
    int w0, r0, w1, r1, bo, n;
    in1 = a < 3'd6;
    req_wr = wr; req_addr = a; req_data = d; req_valid = 1'b1;
    n = 0;
    while (!(b0.req_ready && b1.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(n < 20), 32'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    err_inj   = inj;
    w0 = nwr0; r0 = nrd0; w1 = nwr1; r1 = nrd1; bo = nboth;
    chk("issue_busy", 32'({b0.req_ready, b1.req_ready, b0.rsp_valid, b1.rsp_valid}), 32'(0));
    chk("issue0", 32'({b0.arr_wr, b0.arr_rd, b0.arr_addr}), 32'({wr, !wr, a}));
    chk("issue1", 32'({b1.arr_wr, b1.arr_rd}), 32'(in1 ? {wr, !wr} : 2'b00));
    if (wr) chk("issue_din", 32'(b0.arr_din), 32'(d));
    @(posedge clk); #1;
    err_inj = 1'b0;
    e0e = inj && !wr;
    e1e = !in1 || (inj && !wr);
    e0d = (wr || e0e) ? 8'h00 : ref0[a];
    e1d = (wr || e1e) ? 8'h00 : ref1[a];
    if (wr) ref0[a] = d;
    if (wr && in1) ref1[a] = d;
    if (e0e && rc0 < 255) rc0++;
    if (e1e && rc1 < 255) rc1++;
    chk("wr_pulse0", nwr0 - w0, 32'(wr));
    chk("rd_pulse0", nrd0 - r0, 32'(!wr));
    chk("wr_pulse1", nwr1 - w1, 32'(wr && in1));
    chk("rd_pulse1", nrd1 - r1, 32'(!wr && in1));
    chk("rd_wr_overlap", nboth - bo, 32'(0));
    for (int i = 0; i <= hold; i++) begin
      chk("rsp0", 32'({b0.rsp_valid, b0.req_ready, b0.rsp_err, b0.rsp_data}), 32'({2'b10, e0e, e0d}));
      chk("rsp1", 32'({b1.rsp_valid, b1.req_ready, b1.rsp_err, b1.rsp_data}), 32'({2'b10, e1e, e1d}));
      chk("err_cnt", 32'({cnt1, cnt0}), 32'({8'(rc1), 8'(rc0)}));
      if (i < hold) begin
        @(posedge clk); #1;
      end
    end
    if (rst_mid) do_reset(1);
    else begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("after_rsp", 32'({b0.rsp_valid, b0.req_ready, b1.rsp_valid, b1.req_ready}), 32'(4'b0101));
    end
  endtask
  initial begin
    bit w;
    do_reset(2);
    txn(1'b1, 3'd3, 8'hA5, 1'b0, 0, 1'b0);
    txn(1'b0, 3'd3, 8'h00, 1'b0, 0, 1'b0);
    txn(1'b0, 3'd5, 8'h00, 1'b1, 0, 1'b0);
    txn(1'b0, 3'd7, 8'h00, 1'b0, 0, 1'b0);
    txn(1'b1, 3'd6, 8'h3C, 1'b0, 5, 1'b0);
    txn(1'b0, 3'd6, 8'h00, 1'b0, 5, 1'b0);
    for (int k = 0; k < 80; k++) begin
      w = 1'($urandom);
      txn(w, 3'($urandom_range(7)), 8'($urandom), !w && ($urandom_range(3) == 0),
          int'($urandom_range(2)), 1'b0);
    end
    txn(1'b0, 3'd2, 8'h00, 1'b1, 3, 1'b1);
    txn(1'b0, 3'd4, 8'h00, 1'b0, 0, 1'b0);
    for (int k = 0; k < 260; k++)
      txn(1'b0, 3'($urandom_range(7)), 8'h00, 1'b1, 0, 1'b0);
    chk("err_cnt_sat", 32'({cnt1, cnt0}), 32'(16'hffff));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
